// File: rtl/teclado_clave_pkg.sv
// -----------------------------------------------------------------------------
// teclado_clave_pkg
// Constants shared by the keypad PIN capture block and the access controller:
// FSM state encoding, PIN length and the default inactivity timeout. Also
// provides the digit-shift helper used to build the PIN.
// -----------------------------------------------------------------------------
package teclado_clave_pkg;

   localparam int NUM_DIGITOS        = 4;
   localparam int TIMEOUT_CICLOS_DEF = 1000;
   localparam int CLAVE_W            = 4 * NUM_DIGITOS;
   localparam int CUENTA_W           = 3;

   typedef enum logic [1:0] {
      INACTIVO = 2'd0,
      CAPTURA  = 2'd1,
      COMPLETA = 2'd2,
      ENTREGA  = 2'd3
   } estado_t;

   // First digit typed ends up in the most significant nibble.
   function automatic logic [CLAVE_W-1:0] desplazar(input logic [CLAVE_W-1:0] clave,
                                                    input logic [3:0]         digito);
      return {clave[CLAVE_W-5:0], digito};
   endfunction

endpackage

// File: rtl/teclado_clave_contador_timeout.sv
// -----------------------------------------------------------------------------
// contador_timeout
// Inactivity counter for the PIN entry. Counts enabled cycles since the last
// clear and raises expirado for one cycle when TIMEOUT_CICLOS cycles have gone
// by, then wraps back to zero.
//   clock    : system clock, rising edge
//   reset    : synchronous, active-low
//   limpiar  : restart the count (keypad strobe or nothing to time out)
//   habilitar: count this cycle
//   expirado : one-cycle pulse on the TIMEOUT_CICLOS-th idle cycle
// -----------------------------------------------------------------------------
module contador_timeout #(
   parameter int TIMEOUT_CICLOS = 1000
) (
   input  logic clock,
   input  logic reset,
   input  logic limpiar,
   input  logic habilitar,
   output logic expirado
);

   localparam int CNT_W = $clog2(TIMEOUT_CICLOS + 1);
   localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(TIMEOUT_CICLOS - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Pulse is combinational so the FSM can react on the same edge the
   // counter wraps; a strobe in the same cycle wins over the expiry.
   assign expirado = habilitar && !limpiar && (cnt_q == ULTIMO);

   always_comb begin
      cnt_d = cnt_q;
      if (limpiar || expirado) begin
         cnt_d = '0;
      end else if (habilitar) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every flop samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/teclado_clave.sv
// -----------------------------------------------------------------------------
// teclado_clave
// Captures a 4-digit hex PIN from a keypad decoder while a vehicle is at the
// gate and hands the completed code to the access controller.
//   clock, reset            : system clock; synchronous active-low reset
//   tecla_digito/valida     : digit and its one-cycle strobe
//   tecla_enter/borrar      : confirm / clear strobes (borrar > enter > digit)
//   sensor_llegada_vehiculo : entry only allowed while high
//   senal_alarma_bloqueo    : lockout, aborts and inhibits entry while high
//   clave_ingresada         : last successfully entered PIN (held)
//   clave_lista             : one-cycle pulse, clave_ingresada newly valid
//   cuenta_digitos          : digits captured so far
//   error_entrada           : one-cycle pulse on short enter or timeout
// -----------------------------------------------------------------------------
module teclado_clave
   import teclado_clave_pkg::*;
#(
   parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [3:0]          tecla_digito,
   input  logic                tecla_valida,
   input  logic                tecla_enter,
   input  logic                tecla_borrar,
   input  logic                sensor_llegada_vehiculo,
   input  logic                senal_alarma_bloqueo,
   output logic [CLAVE_W-1:0]  clave_ingresada,
   output logic                clave_lista,
   output logic [CUENTA_W-1:0] cuenta_digitos,
   output logic                error_entrada
);

   estado_t             estado_q, estado_d;
   logic [CLAVE_W-1:0]  buffer_q, buffer_d;
   logic [CLAVE_W-1:0]  clave_q, clave_d;
   logic [CUENTA_W-1:0] cuenta_q, cuenta_d;
   logic                lista_q, lista_d;
   logic                error_q, error_d;

   logic en_captura;
   logic hay_tecla;
   logic expirado;

   assign en_captura = (estado_q == CAPTURA) || (estado_q == COMPLETA);
   assign hay_tecla  = tecla_valida || tecla_enter || tecla_borrar;

   // Timer only runs while a partial PIN exists; it sits at zero otherwise.
   contador_timeout #(
      .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
   ) u_contador_timeout (
      .clock     (clock),
      .reset     (reset),
      .limpiar   (hay_tecla || (cuenta_q == '0) || !en_captura),
      .habilitar (en_captura),
      .expirado  (expirado)
   );

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      estado_d = estado_q;
      buffer_d = buffer_q;
      cuenta_d = cuenta_q;
      clave_d  = clave_q;
      lista_d  = 1'b0;
      error_d  = 1'b0;

      if (!sensor_llegada_vehiculo || senal_alarma_bloqueo) begin
         // Abort from any state; pulses suppressed, delivered PIN kept.
         estado_d = INACTIVO;
         buffer_d = '0;
         cuenta_d = '0;
      end else begin
         case (estado_q)
            INACTIVO: begin
               buffer_d = '0;
               cuenta_d = '0;
               estado_d = CAPTURA;
            end
            CAPTURA: begin
               if (tecla_borrar) begin
                  buffer_d = '0;
                  cuenta_d = '0;
               end else if (tecla_enter) begin
                  buffer_d = '0;
                  cuenta_d = '0;
                  error_d  = 1'b1;
               end else if (tecla_valida) begin
                  buffer_d = desplazar(buffer_q, tecla_digito);
                  cuenta_d = cuenta_q + 1'b1;
                  if (cuenta_q == CUENTA_W'(NUM_DIGITOS - 1)) begin
                     estado_d = COMPLETA;
                  end
               end else if (expirado) begin
                  buffer_d = '0;
                  cuenta_d = '0;
                  error_d  = 1'b1;
               end
            end
            COMPLETA: begin
               // Extra digits are ignored here, but still restart the timer.
               if (tecla_borrar) begin
                  buffer_d = '0;
                  cuenta_d = '0;
                  estado_d = CAPTURA;
               end else if (tecla_enter) begin
                  clave_d  = buffer_q;
                  buffer_d = '0;
                  cuenta_d = '0;
                  lista_d  = 1'b1;
                  estado_d = ENTREGA;
               end else if (expirado) begin
                  buffer_d = '0;
                  cuenta_d = '0;
                  error_d  = 1'b1;
                  estado_d = CAPTURA;
               end
            end
            ENTREGA: begin
               buffer_d = '0;
               cuenta_d = '0;
               estado_d = CAPTURA;
            end
            default: begin
               estado_d = INACTIVO;
               buffer_d = '0;
               cuenta_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: the PIN buffer is reset along with the control state so a PIN
      // typed before reset can never leak into a later delivery.
      if (!reset) begin
         estado_q <= INACTIVO;
         buffer_q <= '0;
         cuenta_q <= '0;
         clave_q  <= '0;
         lista_q  <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         estado_q <= estado_d;
         buffer_q <= buffer_d;
         cuenta_q <= cuenta_d;
         clave_q  <= clave_d;
         lista_q  <= lista_d;
         error_q  <= error_d;
      end
   end

   assign clave_ingresada = clave_q;
   assign clave_lista     = lista_q;
   assign cuenta_digitos  = cuenta_q;
   assign error_entrada   = error_q;

endmodule

// File: tb/tb_teclado_clave.sv
// -----------------------------------------------------------------------------
// tb_teclado_clave
// Directed scenarios followed by randomized keypad/sensor/lockout/reset
// traffic. A queue-based model of the PIN entry rules predicts every output
// each cycle.
// -----------------------------------------------------------------------------
module tb_teclado_clave;

   localparam int T = 8;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  tecla_digito;
   logic        tecla_valida;
   logic        tecla_enter;
   logic        tecla_borrar;
   logic        sensor_llegada_vehiculo;
   logic        senal_alarma_bloqueo;
   logic [15:0] clave_ingresada;
   logic        clave_lista;
   logic [2:0]  cuenta_digitos;
   logic        error_entrada;

   teclado_clave #(.TIMEOUT_CICLOS(T)) dut (
      .clock                   (clock),
      .reset                   (reset),
      .tecla_digito            (tecla_digito),
      .tecla_valida            (tecla_valida),
      .tecla_enter             (tecla_enter),
      .tecla_borrar            (tecla_borrar),
      .sensor_llegada_vehiculo (sensor_llegada_vehiculo),
      .senal_alarma_bloqueo    (senal_alarma_bloqueo),
      .clave_ingresada         (clave_ingresada),
      .clave_lista             (clave_lista),
      .cuenta_digitos          (cuenta_digitos),
      .error_entrada           (error_entrada)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: an entry session holding the typed digits in a queue.
   bit          m_activo;     // session open (vehicle present, no lockout)
   bit          m_entrega;    // cycle right after a successful enter
   logic [3:0]  m_digitos[$];
   int          m_ocioso;     // idle cycles since last strobe with digits held
   logic [15:0] m_clave;
   bit          m_lista;
   bit          m_error;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic void model_step();
      bit tecla;
      m_lista = 1'b0;
      m_error = 1'b0;
      tecla   = tecla_valida || tecla_enter || tecla_borrar;
      if (!reset) begin
         m_activo = 1'b0; m_entrega = 1'b0; m_digitos.delete(); m_ocioso = 0; m_clave = 16'h0;
      end else if (!sensor_llegada_vehiculo || senal_alarma_bloqueo) begin
         m_activo = 1'b0; m_entrega = 1'b0; m_digitos.delete(); m_ocioso = 0;
      end else if (!m_activo) begin
         m_activo = 1'b1; m_digitos.delete(); m_ocioso = 0;
      end else if (m_entrega) begin
         m_entrega = 1'b0; m_digitos.delete(); m_ocioso = 0;
      end else begin
         if (tecla_borrar) begin
            m_digitos.delete();
         end else if (tecla_enter) begin
            if (m_digitos.size() == 4) begin
               m_clave   = {m_digitos[0], m_digitos[1], m_digitos[2], m_digitos[3]};
               m_lista   = 1'b1;
               m_entrega = 1'b1;
            end else begin
               m_error = 1'b1;
            end
            m_digitos.delete();
         end else if (tecla_valida && m_digitos.size() < 4) begin
            m_digitos.push_back(tecla_digito);
         end
         if (tecla || m_digitos.size() == 0) begin
            m_ocioso = 0;
         end else begin
            m_ocioso++;
            if (m_ocioso == T) begin
               m_error = 1'b1;
               m_digitos.delete();
               m_ocioso = 0;
            end
         end
      end
   endfunction

   // One clock cycle with the given strobes; outputs compared 1 time unit
   // after the rising edge.
   task automatic tick(input bit v, input logic [3:0] d, input bit e, input bit b);
      tecla_valida = v;
      tecla_digito = d;
      tecla_enter  = e;
      tecla_borrar = b;
      @(posedge clock);
      model_step();
      #1;
      check("clave", {16'h0, clave_ingresada}, {16'h0, m_clave});
      check("lista", {31'h0, clave_lista}, {31'h0, m_lista});
      check("error", {31'h0, error_entrada}, {31'h0, m_error});
      check("excl",  {31'h0, clave_lista & error_entrada}, 32'h0);
      if (!m_entrega) check("cuenta", {29'h0, cuenta_digitos}, m_digitos.size());
      tecla_valida = 1'b0;
      tecla_enter  = 1'b0;
      tecla_borrar = 1'b0;
   endtask

   task automatic digito(input logic [3:0] d);
      tick(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic ocioso(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 4'h0, 1'b0, 1'b0);
   endtask

   task automatic enter();
      tick(1'b0, 4'h0, 1'b1, 1'b0);
   endtask

   initial begin
      reset = 1'b0;
      sensor_llegada_vehiculo = 1'b0;
      senal_alarma_bloqueo    = 1'b0;
      tecla_digito = 4'h0; tecla_valida = 1'b0; tecla_enter = 1'b0; tecla_borrar = 1'b0;

      // Reset with strobes active: all outputs zero.
      tick(1'b1, 4'h7, 1'b1, 1'b0);
      tick(1'b1, 4'h3, 1'b0, 1'b0);
      check("rst_clave",  {16'h0, clave_ingresada}, 32'h0);
      check("rst_cuenta", {29'h0, cuenta_digitos}, 32'h0);

      reset = 1'b1;
      sensor_llegada_vehiculo = 1'b1;
      ocioso(1);

      // Full PIN, delivered one cycle after enter.
      digito(4'h3); digito(4'h2); digito(4'h5); digito(4'h7);
      enter();
      check("ok_lista", {31'h0, clave_lista}, 32'h1);
      check("ok_clave", {16'h0, clave_ingresada}, 32'h3257);
      ocioso(1);

      // Short PIN: error, previous code kept.
      digito(4'h3); digito(4'h2);
      enter();
      check("corta_error",  {31'h0, error_entrada}, 32'h1);
      check("corta_cuenta", {29'h0, cuenta_digitos}, 32'h0);
      check("corta_clave",  {16'h0, clave_ingresada}, 32'h3257);

      // Fifth digit ignored.
      digito(4'h1); digito(4'h2); digito(4'h3); digito(4'h4); digito(4'h9);
      check("quinto_cuenta", {29'h0, cuenta_digitos}, 32'h4);
      enter();
      check("quinto_clave", {16'h0, clave_ingresada}, 32'h1234);
      ocioso(1);

      // Timeout after T idle cycles, then a good entry.
      digito(4'hA);
      ocioso(T - 1);
      check("pre_timeout", {31'h0, error_entrada}, 32'h0);
      ocioso(1);
      check("timeout_error",  {31'h0, error_entrada}, 32'h1);
      check("timeout_cuenta", {29'h0, cuenta_digitos}, 32'h0);
      digito(4'h3); digito(4'h2); digito(4'h5); digito(4'h7);
      enter();
      check("timeout_clave", {16'h0, clave_ingresada}, 32'h3257);
      ocioso(1);

      // Borrar beats a digit in the same cycle.
      digito(4'h1); digito(4'h2);
      tick(1'b1, 4'h4, 1'b1, 1'b1);
      check("borrar_cuenta", {29'h0, cuenta_digitos}, 32'h0);
      check("borrar_error",  {31'h0, error_entrada}, 32'h0);

      // Vehicle leaves mid-entry.
      digito(4'h1); digito(4'h2); digito(4'h3);
      sensor_llegada_vehiculo = 1'b0;
      ocioso(1);
      check("salida_cuenta", {29'h0, cuenta_digitos}, 32'h0);
      sensor_llegada_vehiculo = 1'b1;
      ocioso(1);

      // Lockout during entry: enter has no effect.
      digito(4'h9); digito(4'h8); digito(4'h7); digito(4'h6);
      senal_alarma_bloqueo = 1'b1;
      enter();
      ocioso(1);
      check("bloqueo_clave", {16'h0, clave_ingresada}, 32'h3257);
      senal_alarma_bloqueo = 1'b0;
      ocioso(1);

      // Reset mid-entry.
      digito(4'h4); digito(4'h5);
      reset = 1'b0;
      ocioso(1);
      check("rst_mid_clave",  {16'h0, clave_ingresada}, 32'h0);
      check("rst_mid_cuenta", {29'h0, cuenta_digitos}, 32'h0);
      reset = 1'b1;
      ocioso(1);

      // Randomized traffic with periodic quiet windows to hit the timeout.
      for (int c = 0; c < 3000; c++) begin
         int r;
         bit v, e, b;
         if (sensor_llegada_vehiculo) begin
            if ($urandom_range(0, 199) == 0) sensor_llegada_vehiculo = 1'b0;
         end else if ($urandom_range(0, 9) == 0) sensor_llegada_vehiculo = 1'b1;
         if (senal_alarma_bloqueo) begin
            if ($urandom_range(0, 19) == 0) senal_alarma_bloqueo = 1'b0;
         end else if ($urandom_range(0, 299) == 0) senal_alarma_bloqueo = 1'b1;
         reset = ($urandom_range(0, 499) != 0);
         r = $urandom_range(0, 99);
         v = (r < 35) || (r >= 96);
         e = (r >= 35 && r < 43) || (r >= 96);
         b = (r >= 43 && r < 46) || (r >= 98);
         if ((c % 150) < 12) begin
            v = 1'b0; e = 1'b0; b = 1'b0;
         end
         tick(v, 4'($urandom_range(0, 15)), e, b);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/teclado_clave.md
TECLADO_CLAVE -- requirements
Module: teclado_clave

Interface
REQ-001 Parameter: TIMEOUT_CICLOS, default 1000; idle cycles allowed between keypad events before the partial entry is discarded.
REQ-002 Parameter: NUM_DIGITOS, fixed 4; hex digits per PIN (16-bit code).
REQ-003 clock  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 tecla_digito  input  4  hex digit from keypad decoder.
REQ-006 tecla_valida  input  1  one-cycle strobe; tecla_digito valid this cycle.
REQ-007 tecla_enter  input  1  one-cycle strobe; user confirms entry.
REQ-008 tecla_borrar  input  1  one-cycle strobe; user clears entry.
REQ-009 sensor_llegada_vehiculo  input  1  vehicle at gate; entry permitted only while high.
REQ-010 senal_alarma_bloqueo  input  1  lockout from downstream access controller; entry inhibited while high.
REQ-011 clave_ingresada  output  16  last completed PIN, first digit in [15:12]; drives access controller.
REQ-012 clave_lista  output  1  one-cycle pulse; clave_ingresada newly valid.
REQ-013 cuenta_digitos  output  3  digits captured so far (0..4).
REQ-014 error_entrada  output  1  one-cycle pulse; incomplete enter or timeout.

Function
REQ-015 FSM states: INACTIVO, CAPTURA, COMPLETA, ENTREGA.
REQ-016 INACTIVO: buffer and count zero; go to CAPTURA when sensor_llegada_vehiculo=1 and senal_alarma_bloqueo=0.
REQ-017 CAPTURA: on tecla_valida, buffer <= {buffer[11:0], tecla_digito}, count +1; at count 4 go to COMPLETA.
REQ-018 COMPLETA: further tecla_valida strobes ignored (no shift, count stays 4).
REQ-019 tecla_enter in COMPLETA: clave_ingresada <= buffer next edge, go to ENTREGA; clave_lista=1 for exactly the ENTREGA cycle (one cycle after enter).
REQ-020 ENTREGA: clear buffer and count, return to CAPTURA if vehicle still present and no lockout, else INACTIVO.
REQ-021 tecla_enter in CAPTURA (count 0..3): error_entrada pulse next cycle, buffer/count cleared, stay CAPTURA; clave_ingresada unchanged.
REQ-022 tecla_borrar in CAPTURA/COMPLETA: buffer/count cleared, state CAPTURA, no error pulse.
REQ-023 Same-cycle priority: borrar > enter > digit; lower-priority strobes that cycle are discarded.
REQ-024 Timeout: counter resets on every keypad strobe; when count>0 and TIMEOUT_CICLOS cycles elapse with no strobe, clear buffer/count, error_entrada pulse, stay CAPTURA; counter idle at count=0.
REQ-025 sensor_llegada_vehiculo falling in any state: abort to INACTIVO next edge, clear buffer/count, no pulses.
REQ-026 senal_alarma_bloqueo=1: abort to INACTIVO, all strobes ignored while high; re-arm per REQ-016.
REQ-027 clave_ingresada holds its value until the next successful entry; never changes on abort, clear, or error.
REQ-028 At most one of clave_lista, error_entrada high in any cycle.

Reset
REQ-029 reset=0 at a rising edge: state INACTIVO, clave_ingresada=16'h0000, clave_lista=0, error_entrada=0, cuenta_digitos=0, timeout counter=0; strobes during reset ignored.
REQ-030 Reset mid-entry discards the partial PIN; no pulse on reset release.

Structure
REQ-031 State encodings, NUM_DIGITOS, and default TIMEOUT_CICLOS in the shared constants include file used with the access controller.
REQ-032 One sub-module contador_timeout (parameter TIMEOUT_CICLOS; inputs clock, reset, limpiar, habilitar; output expirado one-cycle pulse).

Verification
REQ-033 Vehicle present, digits 3,2,5,7 then enter -> clave_lista pulse one cycle after enter, clave_ingresada=16'h3257.
REQ-034 Digits 3,2 then enter -> error_entrada pulse, cuenta_digitos=0, clave_ingresada keeps previous value.
REQ-035 Digits 1,2,3,4,9 then enter -> 9 ignored, clave_ingresada=16'h1234.
REQ-036 TIMEOUT_CICLOS=8, one digit then 8 idle cycles -> error_entrada pulse, count 0; then 3,2,5,7,enter -> 16'h3257.
REQ-037 Digit and borrar same cycle after 2 digits -> count 0, no error; sensor_llegada_vehiculo drop after 3 digits -> INACTIVO, no pulse.
REQ-038 senal_alarma_bloqueo=1 during 4-digit entry plus enter -> no clave_lista; reset=0 mid-entry -> all outputs zero.
